fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Next-generation write-side controller for the async FIFO.
- Generalises the earlier write FSM: parametrised address width, an internal read-pointer synchronizer, a glitch-free registered Gray write pointer, fill/free-space reporting and a programmable almost-full flag.
- Sits in the write clock domain. It drives the RAM write port and exports the Gray write pointer to the read side.

Parameters:
- ADDR_W, 3: RAM address bits; depth DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits; legal ADDR_W >= 2.
- SYNC_STAGES, 2: flops in the read-pointer synchronizer; legal >= 2.
- AFULL_THR, 6: almost_full asserts when used >= AFULL_THR; legal 1..DEPTH.

Ports:
- clk  in  1  write-domain clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request from the producer.
- rptr_gray  in  ADDR_W+1  Gray read pointer from the read domain (asynchronous to clk).
- push  out  1  write accepted this cycle; RAM write enable.
- wr_addr  out  ADDR_W  RAM write address; equals wptr_bin[ADDR_W-1:0].
- wptr_gray  out  ADDR_W+1  registered Gray write pointer to the read domain.
- full  out  1  FIFO full.
- almost_full  out  1  used >= AFULL_THR.
- used  out  ADDR_W+1  entries occupied, 0..DEPTH.
- free  out  ADDR_W+1  DEPTH - used.

Behaviour:
- Reset (arst_n low, asynchronous assert):
  - wptr_bin, wptr_gray and all synchronizer flops go to 0.
  - Outputs: push=0, full=0, almost_full=0, used=0, free=DEPTH.
  - Deassertion is synchronous to clk, handled externally.
  - Reset mid-operation discards all pointer state and the FIFO is empty afterwards; push is forced 0 while arst_n is low.
- Synchronizer: rptr_gray passes through SYNC_STAGES flops and yields rptr_sync. rptr_bin = gray-to-binary(rptr_sync).
- used = (wptr_bin - rptr_bin) modulo 2**(ADDR_W+1). Unsigned, wraps naturally; never exceeds DEPTH.
- full = (used == DEPTH). Equivalent Gray check: wptr_gray MSB two bits are the inverse of rptr_sync, remaining bits equal. Both forms must agree.
- push = wr_en & ~full. Combinational, same cycle as wr_en.
- On a clk edge with push=1:
  - wptr_bin <= wptr_bin + 1, wrapping at 2**(ADDR_W+1).
  - wptr_gray <= bin-to-gray(wptr_bin + 1). It is updated from a flop, never from combinational logic.
- Latency:
  - Write accepted in the cycle wr_en is high and not full.
  - used/full/almost_full reflect that write in the next cycle.
  - A read-side pointer change is visible after SYNC_STAGES clk edges. full and used are therefore pessimistic, never optimistic.
- wr_en while full: ignored, no pointer change, push=0.
- Simultaneous write and read release at full: the write is refused this cycle. It is accepted once the synced rptr advances.
- Wrap-around: after 2**(ADDR_W+1) pushes the pointers return to 0. Full/empty stay distinguishable through the extra MSB.
- No FSM states beyond the pointer registers. Modes, when observed through full: ACCEPT (full=0) and BLOCKED (full=1).

Optional Feature:
- Macro: FIFO_WR_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit) and input ovf_clr (1 bit).
  - ovf is set on the clk edge where wr_en=1 and full=1.
  - ovf is sticky until ovf_clr=1 clears it on the next edge. If set and clear coincide, set wins.
  - ovf resets to 0.
- Not defined: neither port exists, and attempted overflows are silently dropped.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width.
  - localparam helper computing DEPTH from ADDR_W.
- One natural sub-module: sync_ff, an N-stage, width-parametrised flop chain with async active-low reset. The read-side controller reuses it.

Test Plan (ADDR_W=3, DEPTH=8, AFULL_THR=6, SYNC_STAGES=2):
- Reset: arst_n low mid-burst.
  - Required: immediately push=0, full=0, used=0, free=8, wptr_gray=0.
- Fill: wr_en=1 for 10 cycles, rptr_gray=0.
  - Required: push high for exactly 8 cycles; wr_addr 0..7.
  - Required: almost_full from the cycle used=6; full=1 once used=8.
  - Required: wptr_gray sequence 0,1,3,2,6,7,5,4,C.
- Release while full: drive rptr_gray=1 (bin 1).
  - Required: full drops exactly 2 cycles later; used=7; the next wr_en is accepted.
- Wrap-around: cycle 20 writes/reads with rptr tracking.
  - Required: wptr_bin passes 15 to 0; wptr_gray passes 8 to 0; full never falsely asserts; used correct throughout.
- Single-bit change: on every wptr_gray update, check that exactly one bit changes (Hamming distance 1).
- FIFO_WR_OVF_FLAG_EN: wr_en at full.
  - Required: ovf=1 the next cycle and stays set.
  - Required: ovf_clr pulse clears it; simultaneous wr_en-at-full with ovf_clr keeps ovf=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and depth calculation.
package fifo_pkg;

    // Conversions operate on a zero-extended container, so they serve any pointer width up to GRAY_W.
    localparam int GRAY_W = 32;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage, width-parametrised synchronizer flop chain with asynchronous active-low reset.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the async FIFO: write pointer, read-pointer sync, fill/free and flags.
// Optional sticky overflow flag (ports ovf / ovf_clr) enabled by defining FIFO_WR_OVF_FLAG_EN.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_THR   = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_gray,
`ifdef FIFO_WR_OVF_FLAG_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              push,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   used,
    output logic [ADDR_W:0]   free
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_P = PTR_W'(AFULL_THR);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] wptr_bin_nxt;
    logic [PTR_W-1:0] rptr_sync;
    logic [PTR_W-1:0] rptr_bin;

    sync_ff #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (rptr_gray),
        .q      (rptr_sync)
    );

    assign rptr_bin     = PTR_W'(gray2bin(GRAY_W'(rptr_sync)));
    assign used         = wptr_bin - rptr_bin;
    assign free         = DEPTH_P - used;
    assign almost_full  = (used >= AFULL_P);

    // Full in Gray form: write pointer is one lap ahead, i.e. top two bits inverted, rest equal.
    // This matches used == DEPTH since wptr_gray always mirrors wptr_bin.
    assign full         = (wptr_gray == {~rptr_sync[PTR_W-1 -: 2], rptr_sync[PTR_W-3:0]});

    // Gated by arst_n so no RAM write can slip through while reset is asserted.
    assign push         = wr_en & ~full & arst_n;
    assign wr_addr      = wptr_bin[ADDR_W-1:0];
    assign wptr_bin_nxt = wptr_bin + ONE_P;

    // Gray pointer is its own flop so the read domain never samples a combinational glitch.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
        end else if (push) begin
            wptr_bin  <= wptr_bin_nxt;
            wptr_gray <= PTR_W'(bin2gray(GRAY_W'(wptr_bin_nxt)));
        end
    end

`ifdef FIFO_WR_OVF_FLAG_EN
    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised self-checking bench for fifo_wr_ctrl (ADDR_W=3, SYNC_STAGES=2, AFULL_THR=6).
module tb_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int MASK  = 15;
    localparam int THR   = 6;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       wr_en;
    logic       ovf_clr;
    logic [3:0] rptr_gray;
    logic       push;
    logic [2:0] wr_addr;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] used;
    logic [3:0] free;
`ifdef FIFO_WR_OVF_FLAG_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: write count, read count, and a delay line for the read pointer crossing.
    int wcnt;
    int rcnt;
    int sq[$];
    bit m_ovf;

    fifo_wr_ctrl #(
        .ADDR_W      (AW),
        .SYNC_STAGES (2),
        .AFULL_THR   (THR)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .wr_en       (wr_en),
        .rptr_gray   (rptr_gray),
`ifdef FIFO_WR_OVF_FLAG_EN
        .ovf_clr     (ovf_clr),
        .ovf         (ovf),
`endif
        .push        (push),
        .wr_addr     (wr_addr),
        .wptr_gray   (wptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .used        (used),
        .free        (free)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] g4(input int v);
        return 4'(v ^ (v >> 1));
    endfunction

    function automatic int m_used();
        return (wcnt - sq[0]) & MASK;
    endfunction

    task automatic model_reset();
        wcnt  = 0;
        sq    = '{0, 0};
        m_ovf = 1'b0;
    endtask

    task automatic set_rd(input int v);
        rcnt      = v & MASK;
        rptr_gray = g4(rcnt);
    endtask

    // Advance one clock: model predicts this edge, then returns at the following negedge.
    task automatic tick();
        bit f;
        bit p;
        f = (m_used() == DEPTH);
        p = arst_n && wr_en && !f;
        @(posedge clk);
        if (!arst_n) begin
            model_reset();
        end else begin
            if (p) wcnt = (wcnt + 1) & MASK;
            sq.push_back(rcnt);
            void'(sq.pop_front());
            if (wr_en && f) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst_n  = 1'b0;
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        set_rd(0);
        model_reset();
        repeat (2) tick();
        #1;
        tests++; if (used !== 4'd0) begin fails++; $display("FAIL reset_used: got %0d want 0", used); end
        tests++; if (free !== 4'd8) begin fails++; $display("FAIL reset_free: got %0d want 8", free); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_afull: got %b want 0", almost_full); end
`ifdef FIFO_WR_OVF_FLAG_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        arst_n = 1'b1;
        wr_en  = 1'b1;
        repeat (3) tick();
        #1;
        tests++; if (used !== 4'd3) begin fails++; $display("FAIL burst_used: got %0d want 3", used); end
        // Reset asserted mid-burst with wr_en still high.
        arst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (push !== 1'b0) begin fails++; $display("FAIL rst_push: got %b want 0", push); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", full); end
        tests++; if (used !== 4'd0) begin fails++; $display("FAIL rst_used: got %0d want 0", used); end
        tests++; if (free !== 4'd8) begin fails++; $display("FAIL rst_free: got %0d want 8", free); end
        tests++; if (wptr_gray !== 4'd0) begin fails++; $display("FAIL rst_wgray: got %h want 0", wptr_gray); end
        tick();
        #1;
        tests++; if (push !== 1'b0) begin fails++; $display("FAIL rst_hold_push: got %b want 0", push); end
        wr_en  = 1'b0;
        arst_n = 1'b1;
        tick();
        #1;
        tests++; if (used !== 4'd0) begin fails++; $display("FAIL post_rst_used: got %0d want 0", used); end
    endtask

    task automatic test_fill();
        logic [3:0] exp_g [9];
        logic [3:0] prev;
        int         pushes;
        exp_g  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        pushes = 0;
        prev   = wptr_gray;
        for (int c = 0; c < 10; c++) begin
            int k;
            k     = (c < 8) ? c : 8;
            wr_en = 1'b1;
            #1;
            tests++; if (push !== (c < 8)) begin fails++; $display("FAIL fill_push c=%0d: got %b want %b", c, push, (c < 8)); end
            tests++; if (used !== 4'(k)) begin fails++; $display("FAIL fill_used c=%0d: got %0d want %0d", c, used, k); end
            tests++; if (free !== 4'(8 - k)) begin fails++; $display("FAIL fill_free c=%0d: got %0d want %0d", c, free, 8 - k); end
            tests++; if (almost_full !== (k >= THR)) begin fails++; $display("FAIL fill_afull c=%0d: got %b want %b", c, almost_full, (k >= THR)); end
            tests++; if (full !== (k == DEPTH)) begin fails++; $display("FAIL fill_full c=%0d: got %b want %b", c, full, (k == DEPTH)); end
            tests++; if (wptr_gray !== exp_g[k]) begin fails++; $display("FAIL fill_wgray c=%0d: got %h want %h", c, wptr_gray, exp_g[k]); end
            if (c < 8) begin
                tests++; if (wr_addr !== 3'(c)) begin fails++; $display("FAIL fill_addr c=%0d: got %0d want %0d", c, wr_addr, c); end
            end
            if (wptr_gray !== prev) begin
                tests++; if ($countones(wptr_gray ^ prev) != 1) begin fails++; $display("FAIL fill_hamming: %h -> %h", prev, wptr_gray); end
            end
            prev = wptr_gray;
            if (push === 1'b1) pushes++;
            tick();
        end
        wr_en = 1'b0;
        tests++; if (pushes != 8) begin fails++; $display("FAIL fill_push_count: got %0d want 8", pushes); end
    endtask

    task automatic test_release();
        wr_en = 1'b0;
        set_rd(1);
        #1;
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL rel_full0: got %b want 1", full); end
        tick();
        #1;
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL rel_full1: got %b want 1", full); end
        tick();
        #1;
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL rel_full2: got %b want 0", full); end
        tests++; if (used !== 4'd7) begin fails++; $display("FAIL rel_used: got %0d want 7", used); end
        wr_en = 1'b1;
        #1;
        tests++; if (push !== 1'b1) begin fails++; $display("FAIL rel_push: got %b want 1", push); end
        tests++; if (wr_addr !== 3'd0) begin fails++; $display("FAIL rel_addr: got %0d want 0", wr_addr); end
        tick();
        wr_en = 1'b0;
        #1;
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL rel_refull: got %b want 1", full); end
        tests++; if (used !== 4'd8) begin fails++; $display("FAIL rel_used8: got %0d want 8", used); end
    endtask

`ifdef FIFO_WR_OVF_FLAG_EN
    task automatic test_ovf();
        logic [3:0] g0;
        g0      = wptr_gray;
        wr_en   = 1'b1;
        ovf_clr = 1'b0;
        #1;
        tests++; if (push !== 1'b0) begin fails++; $display("FAIL ovf_push: got %b want 0", push); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_pre: got %b want 0", ovf); end
        tick();
        wr_en = 1'b0;
        #1;
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", ovf); end
        tests++; if (wptr_gray !== g0) begin fails++; $display("FAIL ovf_noptr: got %h want %h", wptr_gray, g0); end
        tick();
        #1;
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        #1;
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %b want 0", ovf); end
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        #1;
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
    endtask
`endif

    task automatic test_wrap();
        logic [3:0] prev;
        bit         saw_wrap;
        prev     = wptr_gray;
        saw_wrap = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int u;
            wr_en   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if (((wcnt - rcnt) & MASK) != 0 && $urandom_range(0, 3) != 0) set_rd(rcnt + 1);
            #1;
            u = m_used();
            tests++; if (push !== (wr_en && u != DEPTH)) begin fails++; $display("FAIL wrap_push c=%0d: got %b want %b", c, push, (wr_en && u != DEPTH)); end
            tests++; if (used !== 4'(u)) begin fails++; $display("FAIL wrap_used c=%0d: got %0d want %0d", c, used, u); end
            tests++; if (free !== 4'(DEPTH - u)) begin fails++; $display("FAIL wrap_free c=%0d: got %0d want %0d", c, free, DEPTH - u); end
            tests++; if (full !== (u == DEPTH)) begin fails++; $display("FAIL wrap_full c=%0d: got %b want %b", c, full, (u == DEPTH)); end
            tests++; if (almost_full !== (u >= THR)) begin fails++; $display("FAIL wrap_afull c=%0d: got %b want %b", c, almost_full, (u >= THR)); end
            tests++; if (wr_addr !== 3'(wcnt & 7)) begin fails++; $display("FAIL wrap_addr c=%0d: got %0d want %0d", c, wr_addr, wcnt & 7); end
            tests++; if (wptr_gray !== g4(wcnt)) begin fails++; $display("FAIL wrap_wgray c=%0d: got %h want %h", c, wptr_gray, g4(wcnt)); end
`ifdef FIFO_WR_OVF_FLAG_EN
            tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL wrap_ovf c=%0d: got %b want %b", c, ovf, m_ovf); end
`endif
            if (wptr_gray !== prev) begin
                tests++; if ($countones(wptr_gray ^ prev) != 1) begin fails++; $display("FAIL wrap_hamming: %h -> %h", prev, wptr_gray); end
                if (prev == 4'h8 && wptr_gray == 4'h0) saw_wrap = 1'b1;
            end
            prev = wptr_gray;
            tick();
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        tests++; if (!saw_wrap) begin fails++; $display("FAIL wrap_seen: gray 8->0 transition got 0 want 1"); end
    endtask

    initial begin
        wr_en     = 1'b0;
        ovf_clr   = 1'b0;
        arst_n    = 1'b0;
        rptr_gray = 4'd0;
        rcnt      = 0;
        test_reset();
        test_fill();
        test_release();
`ifdef FIFO_WR_OVF_FLAG_EN
        test_ovf();
`endif
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
